// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a Montgomery multiplier, one op per mmm_start/mmm_done.
// Each op costs one launch cycle plus the multiplier latency; waits on mmm_done indefinitely, start ignored while busy.
module mod_exp_ctrl #(
  parameter int EXP_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [EXP_WIDTH-1:0] exponent,
  output logic                 busy,
  output logic                 done,
  output logic                 mmm_start,
  input  logic                 mmm_done,
  output logic [1:0]           op_a_sel,
  output logic [1:0]           op_b_sel,
  output logic                 x_we,
  output logic                 b_we
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  localparam logic [1:0] A_X    = 2'b00;
  localparam logic [1:0] A_ONE  = 2'b10;
  localparam logic [1:0] B_X    = 2'b00;
  localparam logic [1:0] B_BP   = 2'b01;
  localparam logic [1:0] B_R2   = 2'b10;
  localparam logic [1:0] B_BASE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    INIT_X,
    SQUARE,
    MULT,
    CONVERT,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 mmm_start_q, mmm_start_d;
  logic [1:0]           op_a_sel_q, op_a_sel_d;
  logic [1:0]           op_b_sel_q, op_b_sel_d;
  logic                 in_op;
  logic                 op_cmp;

  // The launch cycle never completes an op, so a stale mmm_done there is dropped.
  assign in_op  = state_q inside {LOAD_B, INIT_X, SQUARE, MULT, CONVERT};
  assign op_cmp = in_op && !mmm_start_q && mmm_done;

  assign b_we = op_cmp && (state_q == LOAD_B);
  assign x_we = op_cmp && (state_q != LOAD_B);

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d     = exponent;
          bit_idx_d = IDX_W'(EXP_WIDTH - 1);
          state_d   = LOAD_B;
        end
      end
      LOAD_B:  if (op_cmp) state_d = INIT_X;
      INIT_X:  if (op_cmp) state_d = SQUARE;
      SQUARE, MULT: begin
        if (op_cmp) begin
          if (state_q == SQUARE && exp_q[bit_idx_q]) begin
            state_d = MULT;
          end else if (bit_idx_q != '0) begin
            state_d   = SQUARE;
            bit_idx_d = bit_idx_q - 1'b1;
          end else begin
            state_d = CONVERT;
          end
        end
      end
      CONVERT: if (op_cmp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are valid from the first cycle of each state.
  always_comb begin
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    mmm_start_d = (state_d inside {LOAD_B, INIT_X, SQUARE, MULT, CONVERT}) &&
                  (op_cmp || state_q == IDLE);
    op_a_sel_d  = A_X;
    op_b_sel_d  = B_X;
    case (state_d)
      LOAD_B: begin
        op_a_sel_d = A_ONE;
        op_b_sel_d = B_BASE;
      end
      INIT_X: begin
        op_a_sel_d = A_ONE;
        op_b_sel_d = B_R2;
      end
      MULT: begin
        op_a_sel_d = A_X;
        op_b_sel_d = B_BP;
      end
      CONVERT: begin
        op_a_sel_d = A_ONE;
        op_b_sel_d = B_X;
      end
      default: begin
        op_a_sel_d = A_X;
        op_b_sel_d = B_X;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      bit_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mmm_start_q <= 1'b0;
      op_a_sel_q  <= 2'b00;
      op_b_sel_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      bit_idx_q   <= bit_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mmm_start_q <= mmm_start_d;
      op_a_sel_q  <= op_a_sel_d;
      op_b_sel_q  <= op_b_sel_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mmm_start = mmm_start_q;
  assign op_a_sel  = op_a_sel_q;
  assign op_b_sel  = op_b_sel_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: op-sequence reference from the exponent bits, latency-randomised
// multiplier responder and a plain modular-multiply datapath checked against repeated multiplication.
module tb_mod_exp_ctrl;
  localparam int W       = 10;
  localparam int OP_LB   = 0;
  localparam int OP_IX   = 1;
  localparam int OP_SQ   = 2;
  localparam int OP_MU   = 3;
  localparam int OP_CV   = 4;
  localparam int OP_NONE = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] exponent = '0;
  logic         mmm_done = 1'b0;
  logic         busy, done, mmm_start, x_we, b_we;
  logic [1:0]   op_a_sel, op_b_sel;

  int n_chk = 0;
  int n_pass = 0;

  mod_exp_ctrl #(.EXP_WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .exponent (exponent),
    .busy     (busy),
    .done     (done),
    .mmm_start(mmm_start),
    .mmm_done (mmm_done),
    .op_a_sel (op_a_sel),
    .op_b_sel (op_b_sel),
    .x_we     (x_we),
    .b_we     (b_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, want);
  endtask

  // {op_a_sel, op_b_sel} each operation must present
  function automatic logic [3:0] op_sels(input int op);
    case (op)
      OP_LB:   return 4'b1011;
      OP_IX:   return 4'b1010;
      OP_SQ:   return 4'b0000;
      OP_MU:   return 4'b0001;
      OP_CV:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic longint pow_mod(input longint b, input int e, input longint n);
    longint r;
    r = 1 % n;
    for (int i = 0; i < e; i++) r = (r * b) % n;
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mstart"}, mmm_start, 0);
    check({tag, "_x_we"}, x_we, 0);
    check({tag, "_b_we"}, b_we, 0);
    check({tag, "_a_sel"}, op_a_sel, 0);
    check({tag, "_b_sel"}, op_b_sel, 0);
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after a rising edge.
  task automatic run_op(input logic [W-1:0] e, input int lat_lo, input int lat_hi,
                        input bit noise, input bit junk, input longint base,
                        input longint n, input int abort_sq, output longint x_out);
    int     q[$];
    int     cur_op, cnt, sq_seen, n_starts, want_starts;
    bit     want_busy, want_done, want_launch, launch_now, done_now, cmpl, fin;
    logic [3:0] s;
    longint xr, br, av, bv, res;
    q = {OP_LB, OP_IX};
    for (int i = W - 1; i >= 0; i--) begin
      q.push_back(OP_SQ);
      if (e[i]) q.push_back(OP_MU);
    end
    q.push_back(OP_CV);
    want_starts = q.size();
    cur_op = OP_NONE; cnt = 0; sq_seen = 0; n_starts = 0;
    want_busy = 0; want_done = 0; want_launch = 0; fin = 0;
    xr = 0; br = 0; x_out = 0;
    start = 1'b1;
    exponent = e;
    mmm_done = 1'b0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      @(negedge clk);
      launch_now = want_launch;
      done_now   = want_done;
      want_launch = 0;
      want_done   = 0;
      check("busy", busy, want_busy);
      check("done", done, done_now);
      check("mmm_start", mmm_start, launch_now);
      if (launch_now) begin
        n_starts++;
        if (q.size() == 0) begin
          check("extra_op", 1, 0);
          cur_op = OP_NONE;
        end else begin
          cur_op = q.pop_front();
          s = op_sels(cur_op);
          check("op_a_sel", op_a_sel, s[3:2]);
          check("op_b_sel", op_b_sel, s[1:0]);
          if (cur_op == OP_SQ) sq_seen++;
        end
      end
      if (abort_sq != 0 && cur_op == OP_SQ && !launch_now && sq_seen == abort_sq) begin
        rst_n = 1'b0;
        mmm_done = 1'b1;
        #1;
        check_reset_outputs("abort");
        mmm_done = 1'b0;
        start = 1'b0;
        return;
      end
      cmpl = (cur_op != OP_NONE) && !launch_now && mmm_done;
      check("x_we", x_we, cmpl && cur_op != OP_LB);
      check("b_we", b_we, cmpl && cur_op == OP_LB);
      if (x_we || b_we) begin
        case (op_a_sel)
          2'b00:   av = xr;
          2'b01:   av = br;
          2'b10:   av = 1;
          default: av = 0;
        endcase
        case (op_b_sel)
          2'b00:   bv = xr;
          2'b01:   bv = br;
          2'b10:   bv = 1 % n;
          default: bv = base;
        endcase
        res = (av * bv) % n;
        if (x_we) xr = res;
        if (b_we) br = res;
      end
      if (cmpl) begin
        if (cur_op == OP_CV) want_done = 1;
        else want_launch = 1;
        cur_op = OP_NONE;
      end
      if (cyc == 0) begin
        want_busy = 1;
        want_launch = 1;
      end
      if (done_now) begin
        check("x_final", xr, pow_mod(base, int'(e), n));
        check("ops_left", q.size(), 0);
        check("op_count", n_starts, want_starts);
        x_out = xr;
        want_busy = 0;
        fin = 1;
      end
      @(posedge clk);
      #1;
      if (cnt > 0) begin
        cnt--;
        mmm_done = (cnt == 0);
      end else begin
        mmm_done = 1'b0;
      end
      if (mmm_start) begin
        cnt = int'($urandom_range(lat_hi, lat_lo));
        mmm_done = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      end
      if (junk && want_busy) begin
        start = 1'($urandom_range(1, 0));
        exponent = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    if (!fin) check("timeout", 0, 1);
    start = 1'b0;
    mmm_done = 1'b0;
  endtask

  task automatic idle_chk(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_mstart", mmm_start, 0);
      check("idle_done", done, 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    longint x;
    logic [W-1:0] e;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    mmm_done = 1'b1;
    #1;
    check_reset_outputs("rst");
    start = 1'b0;
    mmm_done = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(10'd0, 3, 3, 1'b0, 1'b0, 4, 497, 0, x);
    check("exp0_x", x, 1);
    run_op(10'h3FF, 1, 3, 1'b1, 1'b0, 7, 1009, 0, x);
    run_op(10'b1000000001, 1, 1, 1'b0, 1'b0, 3, 1000, 0, x);
    run_op(10'd13, 1, 4, 1'b1, 1'b1, 4, 497, 0, x);
    check("junk_run_x", x, 445);
    idle_chk(2);
    run_op(10'd13, 2, 2, 1'b0, 1'b0, 4, 497, 0, x);
    check("e2e_445", x, 445);
    run_op(10'h2AA, 3, 3, 1'b0, 1'b0, 5, 97, 3, x);
    @(posedge clk);
    #1;
    check_reset_outputs("held");
    rst_n = 1'b1;
    run_op(10'h155, 2, 2, 1'b0, 1'b0, 5, 97, 0, x);
    for (int r = 0; r < 6; r++) begin
      e = W'($urandom);
      run_op(e, 1, int'($urandom_range(4, 1)), 1'($urandom_range(1, 0)),
             1'($urandom_range(1, 0)), longint'($urandom_range(1000, 2)),
             longint'($urandom_range(2000, 3)), 0, x);
    end
    idle_chk(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
